// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_port_arbiter: shares one single-port data memory between the CPU     |
// | MM-stage port (fixed priority) and a host/debug port. Defining            |
// | DMEM_ARB_STARVE_EN adds a starvation guard that forces a host grant.      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module dmem_port_arbiter #(
  parameter int AW           = 12,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_in,
  output logic          mem_we,
  input  logic [DW-1:0] mem_out
);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_HOST = 2'd2;

  logic       force_host;
  logic [1:0] rd_owner_q;
  logic [1:0] rd_owner_d;

`ifdef DMEM_ARB_STARVE_EN
  localparam logic [0:0] ST_NORMAL     = 1'b0;
  localparam logic [0:0] ST_FORCE_HOST = 1'b1;
  localparam logic [7:0] LIMIT         = 8'(STARVE_LIMIT);

  logic [0:0] state_q;
  logic [0:0] state_d;
  logic [7:0] wait_cnt_q;
  logic [7:0] wait_cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_NORMAL;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Counter looks at this cycle's grant, so the force decision uses the
  // value the counter is about to take.
  always_comb begin
    wait_cnt_d = 8'd0;
    if (host_req && !host_gnt) begin
      wait_cnt_d = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;
    end
    state_d = ST_NORMAL;
    case (state_q)
      ST_NORMAL:     state_d = (wait_cnt_d == LIMIT) ? ST_FORCE_HOST : ST_NORMAL;
      ST_FORCE_HOST: state_d = ST_NORMAL;
      default:       state_d = ST_NORMAL;
    endcase
  end

  always_comb begin
    force_host = (state_q == ST_FORCE_HOST);
  end
`else
  assign force_host = 1'b0;
`endif

  // Grants are suppressed while reset is asserted so nothing reaches memory.
  always_comb begin
    cpu_gnt  = 1'b0;
    host_gnt = 1'b0;
    if (rst) begin
      if (force_host) begin
        host_gnt = host_req;
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end else if (host_req) begin
        host_gnt = 1'b1;
      end
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;

  always_comb begin
    mem_addr = '0;
    mem_in   = '0;
    mem_we   = 1'b0;
    if (cpu_gnt) begin
      mem_addr = cpu_addr;
      mem_in   = cpu_wdata;
      mem_we   = cpu_we;
    end else if (host_gnt) begin
      mem_addr = host_addr;
      mem_in   = host_wdata;
      mem_we   = host_we;
    end
  end

  always_comb begin
    rd_owner_d = OWN_NONE;
    if (cpu_gnt && !cpu_we) begin
      rd_owner_d = OWN_CPU;
    end else if (host_gnt && !host_we) begin
      rd_owner_d = OWN_HOST;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_owner_q <= OWN_NONE;
    end else begin
      rd_owner_q <= rd_owner_d;
    end
  end

  assign cpu_rvalid  = (rd_owner_q == OWN_CPU);
  assign host_rvalid = (rd_owner_q == OWN_HOST);
  assign cpu_rdata   = mem_out;
  assign host_rdata  = mem_out;

endmodule
`default_nettype wire
